dino_jump_ctrl: RTL and testbench
=================================

Name: dino_jump_ctrl

Overview:
Sequences the dinosaur sprite's vertical position through a fixed six-phase jump trajectory: fast, medium and slow rise, then slow, medium and fast fall. It is driven by a slow motion tick and a jump request. It produces the sprite's top-left Y coordinate for the renderer. It replaces ad-hoc jump logic in the top level, and the renderer and collision logic consume only dino_y and airborne.

Parameters:
GROUND_Y, 240, resting Y coordinate (top-left row); must be >= 144
Y_W, 9, width of dino_y (matches VGA row_addr)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-low (0 = reset)
tick  in  1  motion time base (level, e.g. a divided clock bit); one step per rising edge
jump_req  in  1  jump request level (e.g. decoded key ready); rising edge = request
pause  in  1  1 = freeze trajectory; tick edges ignored
dino_y  out  Y_W  current sprite top Y
airborne  out  1  1 while state != IDLE
phase  out  3  0=IDLE, 1=RISE_F, 2=RISE_M, 3=RISE_S, 4=FALL_S, 5=FALL_M, 6=FALL_F
landed  out  1  one-cycle pulse on the cycle the jump completes

Behaviour:
- Reset (rst=0, async): dino_y=GROUND_Y, state IDLE, step_cnt=0, airborne=0, landed=0, edge-detect registers cleared to 0.
- Edge detect: tick_q and req_q are registered copies of their inputs. tick_e = tick & ~tick_q; req_e = jump_req & ~req_q. Both are evaluated every clk. A level held high produces exactly one event.
- IDLE: on req_e, go to RISE_F with step_cnt=0. dino_y is unchanged in that cycle. Tick edges in IDLE do nothing.
- Airborne step: on a clk edge with tick_e=1 and pause=0, dino_y is updated by the phase delta and step_cnt increments. When step_cnt reaches the phase length, step_cnt clears and the state advances. All of these registers update on the same clk edge.
  - RISE_F: -8, 10 steps
  - RISE_M: -4, 10 steps
  - RISE_S: -2, 12 steps
  - FALL_S: +2, 12 steps
  - FALL_M: +4, 10 steps
  - FALL_F: +8, 10 steps
- Trajectory totals: 64 tick edges. Apex is GROUND_Y-144, reached after edge 32. Net displacement is zero.
- Landing: the 64th step returns to IDLE, dino_y is forced to GROUND_Y (not accumulated), and landed=1 for exactly one clk.
- req_e while airborne is ignored and not remembered, unless the optional feature below is enabled.
- Simultaneous req_e and tick_e in IDLE: only the launch happens. The first displacement occurs on the next tick_e.
- pause=1: the state, step_cnt and dino_y hold. A tick edge that occurs while paused is consumed, not deferred. req_e is still accepted in IDLE while paused, but no motion happens until pause=0.
- Arithmetic: Y_W-bit unsigned, no saturation. The GROUND_Y >= 144 constraint guarantees no underflow.
- Reset mid-jump: asynchronous return to the reset state above. No landed pulse.
- airborne and phase are registered and consistent with the state in the same cycle.

Optional Feature:
DINO_JUMP_BUFFER_EN
- Defined: a 1-bit buf_req register. It is set by req_e during FALL_S, FALL_M or FALL_F, and ignored in rise phases. On landing, if buf_req=1, the state goes directly to RISE_F with step_cnt=0 in the same cycle that landed pulses, and buf_req clears. buf_req is cleared by reset.
- Undefined: no buffer register; req_e while airborne is always dropped.

Test Plan:
- Reset: hold rst=0, toggle tick and jump_req -> dino_y=240, phase=0, airborne=0, landed=0 throughout.
- Full jump: one jump_req pulse, then 64 tick edges -> dino_y=160 after 10 edges, 120 after 20, 96 after 32 (apex), 120 after 44, 160 after 54, 240 after 64; landed pulses once; phase returns to 0.
- Ignored request: jump_req edge at tick 20 and at tick 40 -> trajectory unchanged. Without DINO_JUMP_BUFFER_EN there is no relaunch after landing. With it, the tick-20 request is still ignored and the tick-40 request relaunches as phase=1 in the landing cycle.
- Pause: assert pause after 15 edges (dino_y=140), apply 5 tick edges, deassert -> dino_y stays 140. The next edge gives 136.
- Coincident events: jump_req and tick rise in the same clk while IDLE -> phase=1, dino_y=240. The next tick edge gives 232.
- Async reset at apex: drop rst between clk edges at dino_y=96 -> dino_y=240 and phase=0 immediately, without waiting for a clk edge; no landed pulse.

Source files
------------

// File: rtl/dino_jump_ctrl_if.sv
// Signal bundle between the jump controller and its driver/renderer.
// Master drives tick/jump_req/pause; slave (the controller) returns sprite state.
interface dino_jump_ctrl_if #(
  parameter int Y_W = 9
);
  logic           tick;
  logic           jump_req;
  logic           pause;
  logic [Y_W-1:0] dino_y;
  logic           airborne;
  logic [2:0]     phase;
  logic           landed;

  modport master (
    output tick, jump_req, pause,
    input  dino_y, airborne, phase, landed
  );

  modport slave (
    input  tick, jump_req, pause,
    output dino_y, airborne, phase, landed
  );
endinterface

// File: rtl/dino_jump_ctrl.sv
// Six-phase dinosaur jump sequencer producing the sprite top Y coordinate.
// Optional DINO_JUMP_BUFFER_EN: a request during the fall relaunches on landing.
module dino_jump_ctrl #(
  parameter int GROUND_Y = 240,
  parameter int Y_W      = 9
) (
  input  logic            clk,
  input  logic            rst,
  dino_jump_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RISE_F = 3'd1,
    S_RISE_M = 3'd2,
    S_RISE_S = 3'd3,
    S_FALL_S = 3'd4,
    S_FALL_M = 3'd5,
    S_FALL_F = 3'd6
  } state_t;

  localparam logic [Y_W-1:0] GROUND = Y_W'(GROUND_Y);

  state_t         r_state;
  logic [3:0]     r_step_cnt;
  logic [Y_W-1:0] r_dino_y;
  logic           r_airborne;
  logic           r_landed;
  logic           r_tick_q;
  logic           r_req_q;
  logic           r_buf;

  state_t         w_state_nx;
  logic [3:0]     w_cnt_nx;
  logic [Y_W-1:0] w_y_nx;
  logic           w_landed_nx;
  logic           w_buf_nx;
  logic           w_tick_e;
  logic           w_req_e;
  logic           w_move;
  logic           w_last;

  function automatic logic [3:0] phase_len(input state_t s);
    case (s)
      S_RISE_S, S_FALL_S: phase_len = 4'd12;
      default:            phase_len = 4'd10;
    endcase
  endfunction

  function automatic state_t next_phase(input state_t s);
    case (s)
      S_RISE_F: next_phase = S_RISE_M;
      S_RISE_M: next_phase = S_RISE_S;
      S_RISE_S: next_phase = S_FALL_S;
      S_FALL_S: next_phase = S_FALL_M;
      S_FALL_M: next_phase = S_FALL_F;
      default:  next_phase = S_IDLE;
    endcase
  endfunction

  function automatic logic [Y_W-1:0] step_y(input state_t s, input logic [Y_W-1:0] y);
    case (s)
      S_RISE_F: step_y = y - Y_W'(8);
      S_RISE_M: step_y = y - Y_W'(4);
      S_RISE_S: step_y = y - Y_W'(2);
      S_FALL_S: step_y = y + Y_W'(2);
      S_FALL_M: step_y = y + Y_W'(4);
      S_FALL_F: step_y = y + Y_W'(8);
      default:  step_y = y;
    endcase
  endfunction

  assign w_tick_e = bus.tick & ~r_tick_q;
  assign w_req_e  = bus.jump_req & ~r_req_q;
  assign w_move   = w_tick_e & ~bus.pause;
  assign w_last   = (r_step_cnt == (phase_len(r_state) - 4'd1));

  // Next-state, trajectory and landing-pulse decode.
  always_comb begin
    w_state_nx  = r_state;
    w_cnt_nx    = r_step_cnt;
    w_y_nx      = r_dino_y;
    w_landed_nx = 1'b0;
    w_buf_nx    = r_buf;
`ifdef DINO_JUMP_BUFFER_EN
    if (w_req_e && (r_state == S_FALL_S || r_state == S_FALL_M || r_state == S_FALL_F)) begin
      w_buf_nx = 1'b1;
    end else begin
      w_buf_nx = r_buf;
    end
`else
    w_buf_nx = 1'b0;
`endif
    case (r_state)
      S_IDLE: begin
        if (w_req_e) begin
          w_state_nx = S_RISE_F;
          w_cnt_nx   = 4'd0;
        end else begin
          w_state_nx = S_IDLE;
        end
      end
      S_RISE_F, S_RISE_M, S_RISE_S, S_FALL_S, S_FALL_M, S_FALL_F: begin
        if (!w_move) begin
          w_state_nx = r_state;
        end else if (!w_last) begin
          w_cnt_nx = r_step_cnt + 4'd1;
          w_y_nx   = step_y(r_state, r_dino_y);
        end else if (r_state != S_FALL_F) begin
          w_cnt_nx   = 4'd0;
          w_y_nx     = step_y(r_state, r_dino_y);
          w_state_nx = next_phase(r_state);
        end else begin
          // Final step snaps to ground so the landing never depends on accumulation.
          w_cnt_nx    = 4'd0;
          w_y_nx      = GROUND;
          w_landed_nx = 1'b1;
          w_state_nx  = S_IDLE;
`ifdef DINO_JUMP_BUFFER_EN
          if (r_buf || w_req_e) begin
            w_state_nx = S_RISE_F;
          end else begin
            w_state_nx = S_IDLE;
          end
          w_buf_nx = 1'b0;
`endif
        end
      end
      default: begin
        w_state_nx = S_IDLE;
        w_cnt_nx   = 4'd0;
        w_y_nx     = GROUND;
      end
    endcase
  end

  // State, trajectory, edge-detect and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_step_cnt <= 4'd0;
      r_dino_y   <= GROUND;
      r_airborne <= 1'b0;
      r_landed   <= 1'b0;
      r_tick_q   <= 1'b0;
      r_req_q    <= 1'b0;
      r_buf      <= 1'b0;
    end else begin
      r_state    <= w_state_nx;
      r_step_cnt <= w_cnt_nx;
      r_dino_y   <= w_y_nx;
      r_airborne <= (w_state_nx != S_IDLE);
      r_landed   <= w_landed_nx;
      r_tick_q   <= bus.tick;
      r_req_q    <= bus.jump_req;
      r_buf      <= w_buf_nx;
    end
  end

  assign bus.dino_y   = r_dino_y;
  assign bus.airborne = r_airborne;
  assign bus.phase    = r_state;
  assign bus.landed   = r_landed;

endmodule

// File: tb/tb_dino_jump_ctrl.sv
// Directed bench for dino_jump_ctrl: reset, full jump, ignored requests,
// pause, coincident launch/tick and asynchronous reset at the apex.
module tb_dino_jump_ctrl;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  int   land_cnt;

  dino_jump_ctrl_if #(.Y_W(9)) bus ();

  dino_jump_ctrl #(.GROUND_Y(240), .Y_W(9)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.landed === 1'b1) land_cnt = land_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks = checks + 1;
    assert (obs === exp) else begin
      errors = errors + 1;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk) bus.tick = 1'b1;
    @(negedge clk) bus.tick = 1'b0;
  endtask

  task automatic req();
    @(negedge clk) bus.jump_req = 1'b1;
    @(negedge clk) bus.jump_req = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    land_cnt = 0;
    rst = 1'b0;
    bus.tick = 1'b0;
    bus.jump_req = 1'b0;
    bus.pause = 1'b0;

    // Reset held: inputs toggling must not move anything.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus.tick = ~bus.tick;
      bus.jump_req = ~bus.jump_req;
      check("rst_y", 32'(bus.dino_y), 32'd240);
      check("rst_phase", 32'(bus.phase), 32'd0);
      check("rst_air", 32'(bus.airborne), 32'd0);
      check("rst_land", 32'(bus.landed), 32'd0);
    end
    @(negedge clk);
    bus.tick = 1'b0;
    bus.jump_req = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // Full jump with requests injected at tick 20 and tick 40.
    req();
    check("launch_phase", 32'(bus.phase), 32'd1);
    check("launch_y", 32'(bus.dino_y), 32'd240);
    check("launch_air", 32'(bus.airborne), 32'd1);
    for (int i = 1; i <= 64; i++) begin
      step();
      if (i == 10) begin
        check("e10_y", 32'(bus.dino_y), 32'd160);
        check("e10_ph", 32'(bus.phase), 32'd2);
      end
      if (i == 20) begin
        check("e20_y", 32'(bus.dino_y), 32'd120);
        check("e20_ph", 32'(bus.phase), 32'd3);
        req();
        check("e20_req_y", 32'(bus.dino_y), 32'd120);
        check("e20_req_ph", 32'(bus.phase), 32'd3);
      end
      if (i == 32) begin
        check("apex_y", 32'(bus.dino_y), 32'd96);
        check("apex_ph", 32'(bus.phase), 32'd4);
      end
      if (i == 40) req();
      if (i == 44) begin
        check("e44_y", 32'(bus.dino_y), 32'd120);
        check("e44_ph", 32'(bus.phase), 32'd5);
      end
      if (i == 54) begin
        check("e54_y", 32'(bus.dino_y), 32'd160);
        check("e54_ph", 32'(bus.phase), 32'd6);
      end
      if (i == 63) check("e63_land", 32'(bus.landed), 32'd0);
    end
    check("land_y", 32'(bus.dino_y), 32'd240);
    check("land_pulse", 32'(bus.landed), 32'd1);
`ifdef DINO_JUMP_BUFFER_EN
    check("land_ph_buf", 32'(bus.phase), 32'd1);
    check("land_air_buf", 32'(bus.airborne), 32'd1);
    for (int i = 0; i < 64; i++) step();
`else
    check("land_ph", 32'(bus.phase), 32'd0);
    check("land_air", 32'(bus.airborne), 32'd0);
`endif
    @(negedge clk);
    #1;
    check("land_pulse_end", 32'(bus.landed), 32'd0);
`ifdef DINO_JUMP_BUFFER_EN
    check("land_count", 32'(land_cnt), 32'd2);
`else
    check("land_count", 32'(land_cnt), 32'd1);
`endif
    step();
    step();
    check("no_relaunch_ph", 32'(bus.phase), 32'd0);
    check("no_relaunch_y", 32'(bus.dino_y), 32'd240);

    // Pause freezes trajectory and swallows tick edges.
    req();
    for (int i = 0; i < 15; i++) step();
    check("pre_pause_y", 32'(bus.dino_y), 32'd140);
    bus.pause = 1'b1;
    for (int i = 0; i < 5; i++) step();
    check("pause_y", 32'(bus.dino_y), 32'd140);
    check("pause_ph", 32'(bus.phase), 32'd2);
    bus.pause = 1'b0;
    @(negedge clk);
    check("unpause_hold_y", 32'(bus.dino_y), 32'd140);
    step();
    check("post_pause_y", 32'(bus.dino_y), 32'd136);
    for (int i = 0; i < 48; i++) step();
    check("pause_land_y", 32'(bus.dino_y), 32'd240);
    check("pause_land_ph", 32'(bus.phase), 32'd0);

    // Coincident request and tick edge in IDLE: launch only.
    @(negedge clk);
    @(negedge clk);
    bus.tick = 1'b1;
    bus.jump_req = 1'b1;
    @(negedge clk);
    bus.tick = 1'b0;
    bus.jump_req = 1'b0;
    check("coinc_ph", 32'(bus.phase), 32'd1);
    check("coinc_y", 32'(bus.dino_y), 32'd240);
    step();
    check("coinc_step_y", 32'(bus.dino_y), 32'd232);

    // Asynchronous reset at the apex, between clock edges.
    for (int i = 0; i < 31; i++) step();
    check("apex2_y", 32'(bus.dino_y), 32'd96);
    #2;
    rst = 1'b0;
    #1;
    check("arst_y", 32'(bus.dino_y), 32'd240);
    check("arst_ph", 32'(bus.phase), 32'd0);
    check("arst_air", 32'(bus.airborne), 32'd0);
    check("arst_land", 32'(bus.landed), 32'd0);
    @(negedge clk);
    #1;
`ifdef DINO_JUMP_BUFFER_EN
    check("arst_land_count", 32'(land_cnt), 32'd3);
`else
    check("arst_land_count", 32'(land_cnt), 32'd2);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
